trivium_stream_gen: RTL and testbench

//  Parametrised Trivium keystream generator; successor to the fixed 1-bit, hard-wired-key core.
//  Key/IV load at runtime via a load strobe; warm-up length is configurable.

---
 rtl/trivium_stream_gen.sv | 124 ++++++++++++
 tb/tb_trivium_stream_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_stream_gen.sv
// Trivium keystream generator with runtime key/IV load and configurable warm-up.
// OUT_W cipher steps are unrolled per clock. Each word is delivered on a
// valid/ready handshake.
//
// Handshake: ks_data/ks_valid are registered. A word transfers on a posedge
// where ks_valid & ks_ready are both high. While ks_valid is high and ks_ready
// is low, ks_data, ks_valid and the cipher state stay unchanged, so no bits are
// lost or skipped. A load on the same edge as a transfer drops that word.
module trivium_stream_gen #(
  parameter int OUT_W         = 8,
  parameter int WARMUP_ROUNDS = 1152
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [79:0]      key,
  input  logic [79:0]      iv,
  output logic [OUT_W-1:0] ks_data,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             busy
);

  // Number of clocks spent in warm-up, and the counter that tracks them.
  localparam int N     = (OUT_W > 0) ? (WARMUP_ROUNDS / OUT_W) : 1;
  localparam int CNT_W = (N > 0) ? $clog2(N + 1) : 1;
  localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WARMUP = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  // Reject illegal widths or a warm-up that does not divide evenly into clocks.
  if (OUT_W < 1 || OUT_W > 64) begin : g_bad_out_w
    $error("trivium_stream_gen: OUT_W must be in 1..64");
  end
  if (WARMUP_ROUNDS <= 0 || (OUT_W > 0 && (WARMUP_ROUNDS % OUT_W) != 0)) begin : g_bad_warmup
    $error("trivium_stream_gen: WARMUP_ROUNDS must be >0 and a multiple of OUT_W");
  end

  // Cipher state s[1..288], indexed by the algorithm's own 1-based numbering.
  logic [288:1]     st;
  logic [288:1]     st_next;
  logic [OUT_W-1:0] z_word;
  logic [288:1]     load_image;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // One Trivium step. Bit 288 of the result is z; bits 287:0 are the new state.
  function automatic logic [288:0] step_fn(input logic [288:1] s);
    logic t1, t2, t3, z;
    t1 = s[66] ^ s[93];
    t2 = s[162] ^ s[177];
    t3 = s[243] ^ s[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[91] & s[92]) ^ s[171];
    t2 = t2 ^ (s[175] & s[176]) ^ s[264];
    t3 = t3 ^ (s[286] & s[287]) ^ s[69];
    return {z, s[287:178], t2, s[176:94], t1, s[92:1], t3};
  endfunction

  // Chain OUT_W steps. The earliest z goes to bit 0.
  always_comb begin
    logic [288:1] cur;
    logic [288:0] res;
    cur    = st;
    res    = '0;
    z_word = '0;
    for (int j = 0; j < OUT_W; j++) begin
      res       = step_fn(cur);
      z_word[j] = res[288];
      cur       = res[287:0];
    end
    st_next = cur;
  end

  // Key in s1..s80, IV in s94..s173, and the three ones in s286..s288.
  assign load_image = {3'b111, 108'b0, 4'b0, iv, 13'b0, key};

  // Control FSM, warm-up counter, cipher state and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= '0;
      state    <= S_IDLE;
      cnt      <= '0;
      ks_data  <= '0;
      ks_valid <= 1'b0;
      busy     <= 1'b0;
    end else if (load) begin
      st       <= load_image;
      cnt      <= N_CNT;
      state    <= S_WARMUP;
      ks_valid <= 1'b0;
      busy     <= 1'b1;
    end else begin
      case (state)
        S_WARMUP: begin
          if (en) begin
            st  <= st_next;
            cnt <= cnt - ONE_CNT;
            if (cnt == ONE_CNT) begin
              state <= S_RUN;
              busy  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (en && (!ks_valid || ks_ready)) begin
            st       <= st_next;
            ks_data  <= z_word;
            ks_valid <= 1'b1;
          end else if (ks_valid && ks_ready) begin
            ks_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trivium_stream_gen.sv
// Bench for trivium_stream_gen. It uses a bit-serial reference model, a word
// scoreboard for the OUT_W=8 instance, and stream captures from the OUT_W=1 and
// OUT_W=32 instances.
module tb_trivium_stream_gen;

  localparam logic [79:0] GOLD_KEY = 80'h9719CFC92A9FF688F9AA;
  localparam logic [79:0] GOLD_IV  = 80'hECBB76B09AFF71D0D151;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        en, load, ks_ready;
  logic [79:0] key, iv;
  logic [7:0]  ks_data;
  logic        ks_valid, busy;

  logic        load_a, en_a, ready_a;
  logic [0:0]  d1;
  logic        v1, b1;
  logic [31:0] d32;
  logic        v32, b32;

  trivium_stream_gen #(.OUT_W(8), .WARMUP_ROUNDS(1152)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .key(key), .iv(iv),
    .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready), .busy(busy));

  trivium_stream_gen #(.OUT_W(1), .WARMUP_ROUNDS(1152)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .en(en_a), .load(load_a), .key(key), .iv(iv),
    .ks_data(d1), .ks_valid(v1), .ks_ready(ready_a), .busy(b1));

  trivium_stream_gen #(.OUT_W(32), .WARMUP_ROUNDS(1152)) dut_w32 (
    .clk(clk), .rst_n(rst_n), .en(en_a), .load(load_a), .key(key), .iv(iv),
    .ks_data(d32), .ks_valid(v32), .ks_ready(ready_a), .busy(b32));

  // ---------------- scoreboard ----------------
  logic [7:0]    exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            words_seen = 0;
  int            idx1 = 0;
  int            idx32 = 0;
  logic [1023:0] gold_bits, zero_bits, cap1, cap32;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference: 1152 warm-up steps, then nbits of keystream.
  task automatic model_gen(input logic [79:0] k, input logic [79:0] v, output logic [1023:0] bits);
    bit s[1:288];
    bit t1, t2, t3, z;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = k[i-1];
      s[93 + i] = v[i-1];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    bits = '0;
    for (int n = 0; n < 1152 + 1024; n++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i > 178; i--) s[i] = s[i-1];
      s[178] = t2;
      for (int i = 177; i > 94; i--) s[i] = s[i-1];
      s[94] = t1;
      for (int i = 93; i > 1; i--) s[i] = s[i-1];
      s[1] = t3;
      if (n >= 1152) bits[n-1152] = z;
    end
  endtask

  // ---------------- driver ----------------
  // Inputs are set 1 time unit after an edge. tick() first records the transfers
  // the next edge will perform, then advances past that edge.
  task automatic tick();
    logic [7:0] w;
    if (ks_valid && ks_ready && !load) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL q_underflow observed=%0h expected=nonempty", exp_q.size());
      end
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("word", {56'b0, ks_data}, {56'b0, w});
      end
      words_seen++;
    end
    if (v1 && ready_a && idx1 < 1024) begin
      cap1[idx1] = d1[0];
      idx1++;
    end
    if (v32 && ready_a && idx32 < 32) begin
      cap32[idx32*32 +: 32] = d32;
      idx32++;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int edges;
    int busy_cnt;
    int guard;
    rst_n = 1'b0; en = 1'b1; load = 1'b0; key = '0; iv = '0; ks_ready = 1'b1;
    load_a = 1'b0; en_a = 1'b1; ready_a = 1'b1;
    cap1 = '0; cap32 = '0;
    model_gen(GOLD_KEY, GOLD_IV, gold_bits);
    model_gen(80'h0, 80'h0, zero_bits);
    #2;
    check("rst_valid", ks_valid, 1'b0);
    check("rst_data", ks_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_w32_valid", v32, 1'b0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("idle_valid", ks_valid, 1'b0);
    check("idle_busy", busy, 1'b0);

    // Golden key/IV load into all three instances.
    for (int i = 0; i < 128; i++) exp_q.push_back(gold_bits[i*8 +: 8]);
    key = GOLD_KEY; iv = GOLD_IV; load = 1'b1; load_a = 1'b1;
    tick();
    load = 1'b0; load_a = 1'b0;
    check("load_busy", busy, 1'b1);
    check("load_valid", ks_valid, 1'b0);
    edges = 1;
    busy_cnt = busy ? 1 : 0;
    while (!ks_valid && edges < 400) begin
      tick();
      edges++;
      if (busy) busy_cnt++;
    end
    check("first_valid_edges", edges, 146);
    check("busy_cycles", busy_cnt, 144);

    repeat (20) tick();

    // Backpressure: the pending word must stay unchanged.
    check("bp_valid_before", ks_valid, 1'b1);
    ks_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", ks_valid, 1'b1);
      check("bp_data", {56'b0, ks_data}, {56'b0, exp_q[0]});
    end
    ks_ready = 1'b1;
    guard = 0;
    while (words_seen < 64 && guard < 200) begin
      tick();
      guard++;
    end
    check("gold_words", words_seen >= 64, 1'b1);

    // Reload with zero key/IV while a word is pending and ready is high.
    check("reload_valid_before", ks_valid, 1'b1);
    key = '0; iv = '0; load = 1'b1;
    tick();
    load = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(zero_bits[i*8 +: 8]);
    check("reload_valid", ks_valid, 1'b0);
    check("reload_busy", busy, 1'b1);
    edges = 1;
    busy_cnt = busy ? 1 : 0;
    repeat (5) begin
      tick(); edges++; if (busy) busy_cnt++;
    end
    en = 1'b0;
    repeat (10) begin
      tick(); edges++; if (busy) busy_cnt++;
    end
    en = 1'b1;
    while (!ks_valid && edges < 400) begin
      tick();
      edges++;
      if (busy) busy_cnt++;
    end
    check("stall_first_valid_edges", edges, 156);
    check("stall_busy_cycles", busy_cnt, 154);

    // Drain with random ready and enable.
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      ks_ready = ($urandom_range(0, 3) != 0);
      en       = ($urandom_range(0, 4) != 0);
      tick();
      guard++;
    end
    ks_ready = 1'b0;
    en = 1'b1;
    check("drain_empty", exp_q.size(), 0);

    // Wait for the width-sweep captures and compare them with the model.
    guard = 0;
    while ((idx1 < 1024 || idx32 < 32) && guard < 4000) begin
      tick();
      guard++;
    end
    check("w1_count", idx1, 1024);
    check("w32_count", idx32, 32);
    for (int c = 0; c < 32; c++) check("w1_chunk", cap1[c*32 +: 32], gold_bits[c*32 +: 32]);
    for (int c = 0; c < 32; c++) check("w32_chunk", cap32[c*32 +: 32], gold_bits[c*32 +: 32]);

    // Asynchronous reset mid-RUN with no clock edge.
    check("prereset_valid", ks_valid, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", ks_valid, 1'b0);
    check("async_rst_data", ks_data, 8'h00);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_w1_valid", v1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ks_ready = 1'b1;
    tick(); tick(); tick();
    check("post_rst_idle_valid", ks_valid, 1'b0);
    check("post_rst_idle_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net in case the sequence stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
